// File: rtl/two_pulse_inc_gen_if.sv
// ============================================================================
// Module   : two_pulse_inc_gen_if
// Purpose  : Control/status bundle for the two-pulse increment generator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface two_pulse_inc_gen_if #(
  parameter int CNT_W = 4
);
  logic             start;
  logic [CNT_W-1:0] num;
  logic             abort;
  logic             inc_out;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] sent;

  modport master (
    output start, num, abort,
    input  inc_out, busy, done, remaining, sent
  );

  modport slave (
    input  start, num, abort,
    output inc_out, busy, done, remaining, sent
  );
endinterface

`default_nettype wire

// File: rtl/two_pulse_inc_gen.sv
// ============================================================================
// Module   : two_pulse_inc_gen
// Purpose  : Emits a train of N two-cycle-wide increment pulses with a
//            programmable low gap; start/busy/done handshake, safe abort.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module two_pulse_inc_gen #(
  parameter int CNT_W      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  wire logic         clk,
  input  wire logic         rst,
  two_pulse_inc_gen_if.slave bus
);

  localparam int             GAP_W    = 4;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIGH1 = 2'd1,
    HIGH2 = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t           state;
  logic [GAP_W-1:0] gap_cnt;
  logic             abort_lat;
  logic [CNT_W-1:0] num_lat;
  logic [CNT_W-1:0] remaining_r;
  logic [CNT_W-1:0] sent_r;
  logic             inc_r;
  logic             busy_r;
  logic             done_r;

  logic             last_pulse;
  logic             end_train;

  assign last_pulse = (remaining_r <= CNT_W'(1));
  // An abort arriving in the HIGH2 cycle itself still ends the train here.
  assign end_train  = last_pulse | abort_lat | bus.abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      gap_cnt     <= '0;
      abort_lat   <= 1'b0;
      num_lat     <= '0;
      remaining_r <= '0;
      sent_r      <= '0;
      inc_r       <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            sent_r      <= '0;
            remaining_r <= bus.num;
            num_lat     <= bus.num;
            abort_lat   <= 1'b0;
            if (bus.num != '0) begin
              state  <= HIGH1;
              inc_r  <= 1'b1;
              busy_r <= 1'b1;
            end else begin
              done_r <= 1'b1;
            end
          end
        end

        HIGH1: begin
          state <= HIGH2;
          if (bus.abort) begin
            abort_lat <= 1'b1;
          end
        end

        HIGH2: begin
          if (remaining_r != '0) begin
            remaining_r <= remaining_r - CNT_W'(1);
          end
          if (sent_r != num_lat) begin
            sent_r <= sent_r + CNT_W'(1);
          end
          inc_r <= 1'b0;
          if (end_train) begin
            state     <= IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            abort_lat <= 1'b0;
          end else begin
            state   <= GAP;
            gap_cnt <= GAP_LOAD;
          end
        end

        GAP: begin
          if (bus.abort) begin
            state  <= IDLE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end else if (gap_cnt == '0) begin
            state <= HIGH1;
            inc_r <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end

        default: begin
          state  <= IDLE;
          inc_r  <= 1'b0;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.inc_out   = inc_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.remaining = remaining_r;
  assign bus.sent      = sent_r;

endmodule

`default_nettype wire

// File: tb/tb_two_pulse_inc_gen.sv
// ============================================================================
// Module   : tb_two_pulse_inc_gen
// Purpose  : Scoreboard bench: lane 0 uses GAP_CYCLES=1, lane 1 GAP_CYCLES=3.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_two_pulse_inc_gen;

  typedef struct {
    int sent;
    int rem;
    int pulses;
    int busy;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       start_s [2];
  logic [3:0] num_s   [2];
  logic       abort_s [2];
  logic       inc_o   [2];
  logic       busy_o  [2];
  logic       done_o  [2];
  logic [3:0] rem_o   [2];
  logic [3:0] sent_o  [2];

  exp_t exp_q [2][$];
  int   vectors     = 0;
  int   miscompares = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int GAP = (g == 0) ? 1 : 3;

    two_pulse_inc_gen_if #(.CNT_W(4)) bus ();

    assign bus.start = start_s[g];
    assign bus.num   = num_s[g];
    assign bus.abort = abort_s[g];
    assign inc_o[g]  = bus.inc_out;
    assign busy_o[g] = bus.busy;
    assign done_o[g] = bus.done;
    assign rem_o[g]  = bus.remaining;
    assign sent_o[g] = bus.sent;

    two_pulse_inc_gen #(.CNT_W(4), .GAP_CYCLES(GAP)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    // Monitor: pulse shape, in-train gap, and end-of-train scoreboard pop.
    initial begin
      int   hi_run = 0;
      int   lo_run = 0;
      int   pulses = 0;
      int   busy_cnt = 0;
      logic prev_inc = 1'b0;
      exp_t e;
      forever begin
        @(negedge clk);
        if (rst) begin
          hi_run = 0; lo_run = 0; pulses = 0; busy_cnt = 0; prev_inc = 1'b0;
        end else begin
          if (inc_o[g]) begin
            if (!prev_inc && pulses > 0) check("gap_len", lo_run, GAP);
            hi_run++;
            lo_run = 0;
          end else begin
            if (prev_inc) begin
              check("pulse_width", hi_run, 2);
              pulses++;
              hi_run = 0;
            end
            lo_run++;
          end
          if (busy_o[g]) busy_cnt++;
          if (done_o[g]) begin
            if (exp_q[g].size() == 0) begin
              check("unexpected_done", 1, 0);
            end else begin
              e = exp_q[g].pop_front();
              check("sent",        int'(sent_o[g]), e.sent);
              check("remaining",   int'(rem_o[g]),  e.rem);
              check("pulse_count", pulses,          e.pulses);
              check("busy_cycles", busy_cnt,        e.busy);
              check("busy_at_done", int'(busy_o[g]), 0);
            end
            pulses   = 0;
            busy_cnt = 0;
          end
          prev_inc = inc_o[g];
        end
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic start_train(input int lane, input int n, input int es,
                             input int er, input int ep, input int eb);
    exp_t e;
    e.sent = es; e.rem = er; e.pulses = ep; e.busy = eb;
    exp_q[lane].push_back(e);
    start_s[lane] = 1'b1;
    num_s[lane]   = 4'(n);
    @(posedge clk); #1;
    start_s[lane] = 1'b0;
    num_s[lane]   = 4'd0;
    check("first_pulse_latency", int'(inc_o[lane]), (n != 0) ? 1 : 0);
    if (n == 0) check("zero_done", int'(done_o[lane]), 1);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle(input int lane, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (exp_q[lane].size() == 0 && !busy_o[lane]) break;
      step(1);
    end
    if (i == budget) check("idle_timeout", 1, 0);
    step(2);
  endtask

  task automatic check_quiet(input int lane);
    check("rst_inc_out",   int'(inc_o[lane]),  0);
    check("rst_busy",      int'(busy_o[lane]), 0);
    check("rst_done",      int'(done_o[lane]), 0);
    check("rst_remaining", int'(rem_o[lane]),  0);
    check("rst_sent",      int'(sent_o[lane]), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    for (int l = 0; l < 2; l++) begin
      start_s[l] = 1'b1;
      num_s[l]   = 4'd5;
      abort_s[l] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    check_quiet(0);
    check_quiet(1);
    rst = 1'b0;
    for (int l = 0; l < 2; l++) begin
      start_s[l] = 1'b0;
      num_s[l]   = 4'd0;
    end
    step(1);
    check("post_rst_inc_out", int'(inc_o[0]), 0);
    check("post_rst_busy",    int'(busy_o[0]), 0);
    step(2);

    // Basic train, num=3: done in cycle k+9, busy k+1..k+8.
    start_train(0, 3, 3, 0, 3, 8);
    wait_idle(0, 40);

    // Zero count.
    start_train(0, 0, 0, 0, 0, 0);
    wait_idle(0, 10);

    // Abort during the second HIGH1 of a 6-pulse train.
    start_train(0, 6, 2, 4, 2, 5);
    step(3);
    abort_s[0] = 1'b1;
    step(1);
    abort_s[0] = 1'b0;
    wait_idle(0, 40);

    // Abort in the gap after the first pulse.
    start_train(0, 4, 1, 3, 1, 3);
    step(2);
    abort_s[0] = 1'b1;
    step(1);
    abort_s[0] = 1'b0;
    wait_idle(0, 40);

    // start/num presented while busy must be ignored.
    start_train(0, 2, 2, 0, 2, 5);
    step(1);
    start_s[0] = 1'b1;
    num_s[0]   = 4'd9;
    step(2);
    start_s[0] = 1'b0;
    num_s[0]   = 4'd0;
    wait_idle(0, 40);

    // Back-to-back: new start presented in the done cycle.
    start_train(0, 2, 2, 0, 2, 5);
    step(5);
    check("b2b_done_cycle",  int'(done_o[0]), 1);
    check("b2b_low_between", int'(inc_o[0]),  0);
    start_train(0, 1, 1, 0, 1, 2);
    wait_idle(0, 20);

    // Lane 1, GAP_CYCLES=3, max count: 15*2 high + 14*3 gap busy cycles.
    start_train(1, 15, 15, 0, 15, 72);
    wait_idle(1, 200);
    check("max_remaining_no_wrap", int'(rem_o[1]), 0);

    for (int l = 0; l < 2; l++) check("queue_drained", exp_q[l].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
